// File: rtl/auction_pkg.sv
// rtl/auction_pkg.sv - shared FSM state type and bus width helper for the auction bid collector
package auction_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic int bus_width(input int n, input int w);
      return (2 ** n) * w;
   endfunction

endpackage

// File: rtl/auction_bid_collector.sv
// rtl/auction_bid_collector.sv - collects one bid per bidder into a packed vector and presents it downstream
// Optional reserve-price filtering is enabled by defining AUCTION_RESERVE_EN.
module auction_bid_collector
   import auction_pkg::*;
#(
   parameter int             N       = 2,
   parameter int             W       = 16,
   parameter logic [W-1:0]   MIN_BID = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       bid_valid,
   output logic                       bid_ready,
   input  logic [N-1:0]               bid_id,
   input  logic [W-1:0]               bid_value,
   input  logic                       close,
   output logic                       bids_valid,
   input  logic                       bids_ready,
   output logic [bus_width(N,W)-1:0]  bids,
   output logic [(2**N)-1:0]          submitted,
   output logic                       dup_err,
   output logic                       reject
);

   localparam int B = 2 ** N;

   state_t       state;
   state_t       state_next;
   logic         accept;
   logic         below;
   logic         fresh;
   logic         dup;
   logic [B-1:0] id_onehot;
   logic [B-1:0] submitted_next;

   assign id_onehot = {{(B-1){1'b0}}, 1'b1} << bid_id;
   assign accept    = bid_valid && bid_ready;

`ifdef AUCTION_RESERVE_EN
   assign below = bid_value < MIN_BID;
`else
   assign below = 1'b0;
`endif

   // A below-reserve bid is dropped before the duplicate check, so it never flags dup_err.
   assign fresh          = accept && !below && !submitted[bid_id];
   assign dup            = accept && !below && submitted[bid_id];
   assign submitted_next = fresh ? (submitted | id_onehot) : submitted;

   always_comb begin
      state_next = state;
      bid_ready  = 1'b0;
      bids_valid = 1'b0;
      case (state)
         COLLECT: begin
            bid_ready = 1'b1;
            if ((&submitted_next) || close)
               state_next = PRESENT;
         end
         PRESENT: begin
            bids_valid = 1'b1;
            if (bids_ready)
               state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         bids      <= '0;
         submitted <= '0;
         dup_err   <= 1'b0;
      end else begin
         state   <= state_next;
         dup_err <= dup;
         if (state == PRESENT && bids_ready) begin
            bids      <= '0;
            submitted <= '0;
         end else if (fresh) begin
            submitted <= submitted_next;
            for (int i = 0; i < B; i++) begin
               if (bid_id == N'(i))
                  bids[i*W +: W] <= bid_value;
            end
         end
      end
   end

`ifdef AUCTION_RESERVE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         reject <= 1'b0;
      else
         reject <= accept && below;
   end
`else
   assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_auction_bid_collector.sv
// tb/tb_auction_bid_collector.sv - table-driven self-checking bench for auction_bid_collector
module tb_auction_bid_collector;

   logic        clk;
   logic        rst;
   logic        bid_valid;
   logic        bid_ready;
   logic [1:0]  bid_id;
   logic [15:0] bid_value;
   logic        close;
   logic        bids_valid;
   logic        bids_ready;
   logic [63:0] bids;
   logic [3:0]  submitted;
   logic        dup_err;
   logic        reject;

   int n_cmp;
   int n_bad;

   auction_bid_collector #(.N(2), .W(16), .MIN_BID(16'd50)) dut (
      .clk        (clk),
      .rst        (rst),
      .bid_valid  (bid_valid),
      .bid_ready  (bid_ready),
      .bid_id     (bid_id),
      .bid_value  (bid_value),
      .close      (close),
      .bids_valid (bids_valid),
      .bids_ready (bids_ready),
      .bids       (bids),
      .submitted  (submitted),
      .dup_err    (dup_err),
      .reject     (reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        bv;
      logic [1:0]  id;
      logic [15:0] val;
      logic        cl;
      logic        br;
      logic        e_ready;
      logic        e_valid;
      logic [3:0]  e_sub;
      logic [63:0] e_bids;
      logic        e_dup;
      logic        e_rej;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_ready, input logic e_valid,
                            input logic [3:0] e_sub, input logic [63:0] e_bids,
                            input logic e_dup, input logic e_rej);
      check({tag, ".bid_ready"},  64'(bid_ready),  64'(e_ready));
      check({tag, ".bids_valid"}, 64'(bids_valid), 64'(e_valid));
      check({tag, ".submitted"},  64'(submitted),  64'(e_sub));
      check({tag, ".bids"},       bids,            e_bids);
      check({tag, ".dup_err"},    64'(dup_err),    64'(e_dup));
      check({tag, ".reject"},     64'(reject),     64'(e_rej));
   endtask

   task automatic set_vec(input int k, input logic bv, input logic [1:0] id, input logic [15:0] val,
                          input logic cl, input logic br, input logic er, input logic ev,
                          input logic [3:0] es, input logic [63:0] eb, input logic ed, input logic ej);
      vecs[k].bv = bv;  vecs[k].id = id;  vecs[k].val = val;
      vecs[k].cl = cl;  vecs[k].br = br;
      vecs[k].e_ready = er;  vecs[k].e_valid = ev;  vecs[k].e_sub = es;
      vecs[k].e_bids = eb;   vecs[k].e_dup = ed;    vecs[k].e_rej = ej;
   endtask

   task automatic drive(input logic bv, input logic [1:0] id, input logic [15:0] val,
                        input logic cl, input logic br);
      @(negedge clk);
      bid_valid  = bv;
      bid_id     = id;
      bid_value  = val;
      close      = cl;
      bids_ready = br;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      // Expectations are the outputs one cycle after each vector is applied.
      //        k   bv  id     val     cl br   rdy val sub       bids                    dup rej
      set_vec(0,  1, 2'd0, 16'd5,   0, 0,  1, 0, 4'b0001, 64'h0000_0000_0000_0005, 0, 0);
      set_vec(1,  1, 2'd1, 16'd9,   0, 0,  1, 0, 4'b0011, 64'h0000_0000_0009_0005, 0, 0);
      set_vec(2,  1, 2'd2, 16'd3,   0, 0,  1, 0, 4'b0111, 64'h0000_0003_0009_0005, 0, 0);
      set_vec(3,  1, 2'd3, 16'd7,   0, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(4,  1, 2'd0, 16'd77,  1, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(5,  0, 2'd0, 16'd0,   0, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(6,  0, 2'd0, 16'd0,   0, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(7,  0, 2'd0, 16'd0,   0, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(8,  0, 2'd0, 16'd0,   0, 0,  0, 1, 4'b1111, 64'h0007_0003_0009_0005, 0, 0);
      set_vec(9,  0, 2'd0, 16'd0,   0, 1,  1, 0, 4'b0000, 64'h0, 0, 0);
      set_vec(10, 1, 2'd0, 16'd10,  0, 1,  1, 0, 4'b0001, 64'h0000_0000_0000_000A, 0, 0);
      set_vec(11, 1, 2'd2, 16'd20,  0, 0,  1, 0, 4'b0101, 64'h0000_0014_0000_000A, 0, 0);
      set_vec(12, 0, 2'd0, 16'd0,   1, 0,  0, 1, 4'b0101, 64'h0000_0014_0000_000A, 0, 0);
      set_vec(13, 0, 2'd0, 16'd0,   0, 1,  1, 0, 4'b0000, 64'h0, 0, 0);
      set_vec(14, 1, 2'd1, 16'd8,   0, 0,  1, 0, 4'b0010, 64'h0000_0000_0008_0000, 0, 0);
      set_vec(15, 1, 2'd1, 16'd99,  0, 0,  1, 0, 4'b0010, 64'h0000_0000_0008_0000, 1, 0);
      set_vec(16, 0, 2'd0, 16'd0,   0, 0,  1, 0, 4'b0010, 64'h0000_0000_0008_0000, 0, 0);
      set_vec(17, 1, 2'd3, 16'd4,   1, 0,  0, 1, 4'b1010, 64'h0004_0000_0008_0000, 0, 0);
      set_vec(18, 0, 2'd0, 16'd0,   0, 1,  1, 0, 4'b0000, 64'h0, 0, 0);
      set_vec(19, 0, 2'd0, 16'd0,   1, 0,  0, 1, 4'b0000, 64'h0, 0, 0);
      set_vec(20, 0, 2'd0, 16'd0,   0, 1,  1, 0, 4'b0000, 64'h0, 0, 0);
`ifdef AUCTION_RESERVE_EN
      set_vec(21, 1, 2'd0, 16'd49,  0, 0,  1, 0, 4'b0000, 64'h0, 0, 1);
      set_vec(22, 1, 2'd0, 16'd50,  0, 0,  1, 0, 4'b0001, 64'h0000_0000_0000_0032, 0, 0);
`else
      set_vec(21, 1, 2'd0, 16'd49,  0, 0,  1, 0, 4'b0001, 64'h0000_0000_0000_0031, 0, 0);
      set_vec(22, 1, 2'd0, 16'd50,  0, 0,  1, 0, 4'b0001, 64'h0000_0000_0000_0031, 1, 0);
`endif

      rst        = 1'b1;
      bid_valid  = 1'b0;
      bid_id     = 2'd0;
      bid_value  = 16'd0;
      close      = 1'b0;
      bids_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", 1'b1, 1'b0, 4'b0000, 64'h0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int k = 0; k < NV; k++) begin
         drive(vecs[k].bv, vecs[k].id, vecs[k].val, vecs[k].cl, vecs[k].br);
         check_all($sformatf("vec%0d", k), vecs[k].e_ready, vecs[k].e_valid,
                   vecs[k].e_sub, vecs[k].e_bids, vecs[k].e_dup, vecs[k].e_rej);
      end

      // Complete the round, then reset mid-PRESENT between clock edges.
      drive(1'b1, 2'd1, 16'd1, 1'b0, 1'b0);
      drive(1'b1, 2'd2, 16'd2, 1'b0, 1'b0);
      drive(1'b1, 2'd3, 16'd3, 1'b0, 1'b0);
`ifdef AUCTION_RESERVE_EN
      check_all("full", 1'b0, 1'b1, 4'b1111, 64'h0003_0002_0001_0032, 1'b0, 1'b0);
`else
      check_all("full", 1'b0, 1'b1, 4'b1111, 64'h0003_0002_0001_0031, 1'b0, 1'b0);
`endif
      drive(1'b0, 2'd0, 16'd0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 1'b1, 1'b0, 4'b0000, 64'h0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 2'd2, 16'd42, 1'b0, 1'b0);
      check_all("post_rst", 1'b1, 1'b0, 4'b0100, 64'h0000_002A_0000_0000, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/auction_bid_collector.md
AUCTION_BID_COLLECTOR -- requirements
Module: auction_bid_collector

Interface
REQ-001 SHALL have parameter N, default 2: log2 of bidder count; the bidder count is B = 2**N.
REQ-002 SHALL have parameter W, default 16: bid width in bits.
REQ-003 SHALL have parameter MIN_BID, default 0: reserve price, W bits unsigned; used only under AUCTION_RESERVE_EN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 bid_valid  input  1  upstream bid offered.
REQ-007 bid_ready  output  1  collector accepts a bid this cycle.
REQ-008 bid_id  input  N  bidder index of offered bid.
REQ-009 bid_value  input  W  offered bid amount, unsigned.
REQ-010 close  input  1  end the round early; missing bids read as zero.
REQ-011 bids_valid  output  1  packed bid vector is complete and stable.
REQ-012 bids_ready  input  1  downstream auction stage consumed the vector.
REQ-013 bids  output  B*W  packed bids; bidder i occupies bits [i*W +: W].
REQ-014 submitted  output  B  bit i set when bidder i's bid is recorded.
REQ-015 dup_err  output  1  one-cycle pulse on a duplicate bid.
REQ-016 reject  output  1  one-cycle pulse on a below-reserve bid; tied to 0 without AUCTION_RESERVE_EN.

Function
REQ-017 SHALL implement a two-state FSM: COLLECT and PRESENT.
REQ-018 In COLLECT, bid_ready SHALL be 1 and bids_valid SHALL be 0.
REQ-019 A bid SHALL be accepted on a rising edge where bid_valid and bid_ready are both 1.
REQ-020 On acceptance with submitted[bid_id]=0, SHALL store bid_value in slot bid_id and set submitted[bid_id].
REQ-021 On acceptance with submitted[bid_id]=1, SHALL keep the first value unchanged and pulse dup_err in the following cycle.
REQ-022 SHALL move COLLECT->PRESENT on the edge where submitted becomes all ones, or where close=1.
REQ-023 When close and an accepted bid coincide, SHALL record the bid and then enter PRESENT.
REQ-024 close=1 with submitted all zero SHALL still enter PRESENT, with the vector all zero.
REQ-025 In PRESENT, bid_ready SHALL be 0 and bids_valid SHALL be 1; bids and submitted SHALL remain stable.
REQ-026 In PRESENT, close SHALL be ignored.
REQ-027 SHALL leave PRESENT on the edge where bids_ready=1; on that edge all slots and submitted are cleared to 0 and the FSM returns to COLLECT.
REQ-028 bids_valid SHALL assert in the cycle immediately after the completing edge; latency is one cycle.
REQ-029 Slots not submitted SHALL read as 0 in bids.
REQ-030 bids_ready in COLLECT SHALL have no effect.

Reset
REQ-031 On rst, SHALL asynchronously set: FSM=COLLECT, all slots=0, submitted=0, bids_valid=0, dup_err=0, reject=0.
REQ-032 After reset, bid_ready SHALL be 1 in the first cycle.
REQ-033 A reset during PRESENT SHALL discard the round with no handshake required.

Configuration
REQ-034 Macro AUCTION_RESERVE_EN defined: an accepted bid with bid_value < MIN_BID SHALL be dropped (slot and submitted unchanged) and SHALL pulse reject in the next cycle.
REQ-035 Macro AUCTION_RESERVE_EN defined: a below-reserve bid SHALL NOT count toward completion.
REQ-036 Macro AUCTION_RESERVE_EN undefined: all bids SHALL be treated normally and reject SHALL be constant 0.

Structure
REQ-037 The FSM state typedef (COLLECT, PRESENT) SHALL live in shared package auction_pkg.
REQ-038 auction_pkg SHALL also hold the helper constant function computing B*W.
REQ-039 No sub-module; slot storage and FSM SHALL be inline.
REQ-040 The bids output SHALL connect directly to the bid input of the auction stage.

Verification
REQ-041 N=2, W=16: bids 5,9,3,7 to ids 0..3 on consecutive cycles -> bids_valid the cycle after the 4th; bids=0x0007_0003_0009_0005.
REQ-042 Ids 0 and 2 bid 10 and 20, then close -> PRESENT; bids=0x0000_0014_0000_000A; submitted=4'b0101.
REQ-043 id 1 bids 8, then bids 99 -> dup_err pulses once; slot 1 stays 8.
REQ-044 Full vector held with bids_ready low for 5 cycles -> bids stable and bid_ready=0; then bids_ready=1 -> next cycle submitted=0 and bid_ready=1.
REQ-045 rst asserted mid-PRESENT -> all outputs return to reset values immediately.
REQ-046 AUCTION_RESERVE_EN defined, MIN_BID=50: bid 49 -> reject pulses and submitted is unchanged; bid 50 -> bid accepted.
